ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline, directly downstream of the ALU control decoder.
- Consumes the 3-bit alu_control code plus ID/EX operands, applies forwarding and the immediate mux, and computes the ALU result and branch decision.
- Registers everything into the EX/MEM pipeline register, with stall/flush control from the hazard unit.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold EX/MEM register contents
- flush_i  in  1  load bubble into EX/MEM register
- in_valid  in  1  ID/EX holds a real instruction
- alu_control  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT
- rs1_data, rs2_data  in  XLEN  register-file operands
- imm  in  XLEN  sign-extended immediate
- alu_src  in  1  1: operand B = imm
- fwd_a, fwd_b  in  2  forwarding select: 00 regfile, 01 WB data, 10 MEM data, 11 regfile
- fwd_mem_data, fwd_wb_data  in  XLEN  forwarded values
- pc  in  XLEN  instruction PC
- is_branch  in  1  conditional branch
- func3  in  3  branch condition
- rd  in  5  destination register
- reg_write, mem_write  in  1  control bits
- result_src  in  2  writeback select
- out_valid  out  1  EX/MEM holds a real instruction
- alu_result  out  XLEN  registered ALU result
- write_data  out  XLEN  registered forwarded rs2, used as store data
- rd_out  out  5
- reg_write_out, mem_write_out  out  1
- result_src_out  out  2
- pc_plus4_out  out  XLEN  pc+4, used for JAL writeback
- branch_taken  out  1  registered branch decision
- branch_target  out  XLEN  registered pc+imm

Behaviour:
- Reset (rst_n=0, asynchronous): every output register is cleared to 0, including out_valid, branch_taken and all data fields.
- Operand A is fwd_a-selected. fwd_rs2 is the fwd_b-selected value. Operand B = alu_src ? imm : fwd_rs2. write_data always takes fwd_rs2.
- ALU operations:
  - ADD/SUB wrap mod 2^XLEN.
  - AND/OR/XOR are bitwise.
  - SLT is a signed compare; the result is 1 or 0, zero-extended.
  - Codes 110/111 produce result 0.
- Branch decision:
  - Computed only when is_branch & in_valid. zero = (A-B == 0); lt = signed A < B.
  - func3 000 BEQ: taken on zero. 001 BNE: taken on ~zero. 100 BLT: taken on lt. 101 BGE: taken on ~lt.
  - Any other func3 is not taken.
  - When branch_taken is registered, alu_result still carries the alu_control result.
- Latency: exactly 1 cycle from ID/EX inputs to registered outputs. No combinational input-to-output paths.
- Register update priority at posedge: flush_i > stall_i > normal load.
  - flush_i=1: out_valid, reg_write_out, mem_write_out and branch_taken go to 0. All data fields go to 0. stall_i is ignored.
  - stall_i=1 (no flush): all outputs hold their previous values.
  - Normal load with in_valid=0: load as a bubble (same as flush).
  - Normal load with in_valid=1: all fields are loaded.
- A registered branch_taken is a 1-cycle pulse unless it is held by stall_i. The hazard unit uses it to flush IF/ID and ID/EX.
- Reset asserted mid-operation clears the outputs immediately, regardless of clk. The first load after rst_n deasserts occurs at the first following posedge.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all outputs 0 immediately. Release rst_n; ADD rs1=5, rs2=7, in_valid=1 -> next cycle alu_result=12, out_valid=1.
- ALU coverage:
  - SUB 3-5 -> 0xFFFFFFFE.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - XOR 0xF0F0 vs 0x0FF0 with alu_src=1, imm=0x0FF0 -> 0xFF00.
  - Code 111 -> 0.
  - ADD 0xFFFFFFFF+1 -> 0.
- Forwarding: fwd_a=10 with fwd_mem_data=100, fwd_b=01 with fwd_wb_data=20, SUB -> alu_result=80, write_data=20. Repeat with fwd_a=11 -> uses rs1_data.
- Branches with rs1=rs2=9, pc=0x100, imm=0x20:
  - BEQ -> branch_taken=1, branch_target=0x120.
  - BNE -> 0.
  - rs1=-1, rs2=1 with BLT -> 1; with BGE -> 0.
  - is_branch=1, in_valid=0 -> 0.
- Stall/flush:
  - Load an ADD, then stall_i=1 for 3 cycles with changed inputs -> outputs unchanged.
  - stall_i=1 and flush_i=1 together -> out_valid=0, reg_write_out=0, mem_write_out=0.
- Bubble: in_valid=0 with reg_write=1, mem_write=1 -> reg_write_out=0, mem_write_out=0, out_valid=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RISC-V pipeline.
// Applies operand forwarding and the immediate mux, then computes the ALU
// result and the conditional-branch decision. All results are captured in
// the EX/MEM pipeline register. Priority at each clock edge is
// flush > stall > load. A load with no valid instruction inserts a bubble.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            in_valid,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic [XLEN-1:0] pc,
  input  logic            is_branch,
  input  logic [2:0]      func3,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_write,
  input  logic [1:0]      result_src,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] write_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            mem_write_out,
  output logic [1:0]      result_src_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] BR_BEQ = 3'b000;
  localparam logic [2:0] BR_BNE = 3'b001;
  localparam logic [2:0] BR_BLT = 3'b100;
  localparam logic [2:0] BR_BGE = 3'b101;

  // ALU operation; unused codes yield zero so a bad decode cannot leak data.
  function automatic logic [XLEN-1:0] alu_op(
    input logic [2:0]      ctrl,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    case (ctrl)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLT: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] diff;
  logic            zero;
  logic            lt;
  logic            take;

  logic            nxt_valid;
  logic [XLEN-1:0] nxt_alu;
  logic [XLEN-1:0] nxt_wdata;
  logic [4:0]      nxt_rd;
  logic            nxt_reg_write;
  logic            nxt_mem_write;
  logic [1:0]      nxt_result_src;
  logic [XLEN-1:0] nxt_pc4;
  logic            nxt_taken;
  logic [XLEN-1:0] nxt_target;

  // Forwarding muxes for both operands; 00 and 11 both take the register file.
  always_comb begin
    op_a    = rs1_data;
    fwd_rs2 = rs2_data;
    case (fwd_a)
      2'b01:   op_a = fwd_wb_data;
      2'b10:   op_a = fwd_mem_data;
      default: op_a = rs1_data;
    endcase
    case (fwd_b)
      2'b01:   fwd_rs2 = fwd_wb_data;
      2'b10:   fwd_rs2 = fwd_mem_data;
      default: fwd_rs2 = rs2_data;
    endcase
    if (alu_src) begin
      op_b = imm;
    end else begin
      op_b = fwd_rs2;
    end
  end

  // Branch condition evaluation, qualified by a valid branch instruction.
  always_comb begin
    diff = op_a - op_b;
    zero = (diff == '0);
    lt   = ($signed(op_a) < $signed(op_b));
    take = 1'b0;
    if (is_branch && in_valid) begin
      case (func3)
        BR_BEQ:  take = zero;
        BR_BNE:  take = ~zero;
        BR_BLT:  take = lt;
        BR_BGE:  take = ~lt;
        default: take = 1'b0;
      endcase
    end else begin
      take = 1'b0;
    end
  end

  // Next EX/MEM contents: full load for a real instruction, bubble otherwise.
  always_comb begin
    nxt_valid      = 1'b0;
    nxt_alu        = '0;
    nxt_wdata      = '0;
    nxt_rd         = 5'd0;
    nxt_reg_write  = 1'b0;
    nxt_mem_write  = 1'b0;
    nxt_result_src = 2'd0;
    nxt_pc4        = '0;
    nxt_taken      = 1'b0;
    nxt_target     = '0;
    if (in_valid) begin
      nxt_valid      = 1'b1;
      nxt_alu        = alu_op(alu_control, op_a, op_b);
      nxt_wdata      = fwd_rs2;
      nxt_rd         = rd;
      nxt_reg_write  = reg_write;
      nxt_mem_write  = mem_write;
      nxt_result_src = result_src;
      nxt_pc4        = pc + XLEN'(32'd4);
      nxt_taken      = take;
      nxt_target     = pc + imm;
    end else begin
      nxt_valid      = 1'b0;
    end
  end

  // EX/MEM pipeline register: async reset, then flush > stall > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      write_data     <= '0;
      rd_out         <= 5'd0;
      reg_write_out  <= 1'b0;
      mem_write_out  <= 1'b0;
      result_src_out <= 2'd0;
      pc_plus4_out   <= '0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
    end else if (flush_i) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      write_data     <= '0;
      rd_out         <= 5'd0;
      reg_write_out  <= 1'b0;
      mem_write_out  <= 1'b0;
      result_src_out <= 2'd0;
      pc_plus4_out   <= '0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
    end else if (!stall_i) begin
      out_valid      <= nxt_valid;
      alu_result     <= nxt_alu;
      write_data     <= nxt_wdata;
      rd_out         <= nxt_rd;
      reg_write_out  <= nxt_reg_write;
      mem_write_out  <= nxt_mem_write;
      result_src_out <= nxt_result_src;
      pc_plus4_out   <= nxt_pc4;
      branch_taken   <= nxt_taken;
      branch_target  <= nxt_target;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic
// compared against a behavioural model of the EX/MEM register contents.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        in_valid;
  logic [2:0]  alu_control;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        alu_src;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] fwd_mem_data;
  logic [31:0] fwd_wb_data;
  logic [31:0] pc;
  logic        is_branch;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_write;
  logic [1:0]  result_src;
  logic        out_valid;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_write_out;
  logic [1:0]  result_src_out;
  logic [31:0] pc_plus4_out;
  logic        branch_taken;
  logic [31:0] branch_target;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected EX/MEM contents
  logic        m_valid;
  logic [31:0] m_alu;
  logic [31:0] m_wd;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_mw;
  logic [1:0]  m_rs;
  logic [31:0] m_pc4;
  logic        m_bt;
  logic [31:0] m_tgt;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .alu_control(alu_control),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_data(fwd_wb_data), .pc(pc), .is_branch(is_branch), .func3(func3),
    .rd(rd), .reg_write(reg_write), .mem_write(mem_write),
    .result_src(result_src), .out_valid(out_valid), .alu_result(alu_result),
    .write_data(write_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_write_out(mem_write_out), .result_src_out(result_src_out),
    .pc_plus4_out(pc_plus4_out), .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_alu = 32'd0; m_wd = 32'd0; m_rd = 5'd0; m_rw = 1'b0;
    m_mw = 1'b0; m_rs = 2'd0; m_pc4 = 32'd0; m_bt = 1'b0; m_tgt = 32'd0;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return fwd_wb_data;
    if (sel == 2'b10) return fwd_mem_data;
    return rf;
  endfunction

  // Model of what the register captures at the coming edge.
  task automatic model_clock();
    logic [31:0] a, r2, b;
    logic        lt;
    if (flush_i) begin
      model_clear();
    end else if (stall_i) begin
      m_valid = m_valid;
    end else if (!in_valid) begin
      model_clear();
    end else begin
      a  = pick(fwd_a, rs1_data);
      r2 = pick(fwd_b, rs2_data);
      b  = alu_src ? imm : r2;
      lt = $signed(a) < $signed(b);
      case (alu_control)
        3'd0:    m_alu = a + b;
        3'd1:    m_alu = a - b;
        3'd2:    m_alu = a & b;
        3'd3:    m_alu = a | b;
        3'd4:    m_alu = a ^ b;
        3'd5:    m_alu = lt ? 32'd1 : 32'd0;
        default: m_alu = 32'd0;
      endcase
      case (is_branch ? func3 : 3'd7)
        3'd0:    m_bt = (a == b);
        3'd1:    m_bt = (a != b);
        3'd4:    m_bt = lt;
        3'd5:    m_bt = !lt;
        default: m_bt = 1'b0;
      endcase
      m_valid = 1'b1; m_wd = r2; m_rd = rd; m_rw = reg_write; m_mw = mem_write;
      m_rs = result_src; m_pc4 = pc + 32'd4; m_tgt = pc + imm;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"},  {31'd0, out_valid},      {31'd0, m_valid});
    check({tag, ".alu_result"}, alu_result,              m_alu);
    check({tag, ".write_data"}, write_data,              m_wd);
    check({tag, ".rd_out"},     {27'd0, rd_out},         {27'd0, m_rd});
    check({tag, ".reg_write"},  {31'd0, reg_write_out},  {31'd0, m_rw});
    check({tag, ".mem_write"},  {31'd0, mem_write_out},  {31'd0, m_mw});
    check({tag, ".result_src"}, {30'd0, result_src_out}, {30'd0, m_rs});
    check({tag, ".pc_plus4"},   pc_plus4_out,            m_pc4);
    check({tag, ".taken"},      {31'd0, branch_taken},   {31'd0, m_bt});
    check({tag, ".target"},     branch_target,           m_tgt);
  endtask

  // One clock: predict, clock, sample 1 time unit after the edge, compare.
  task automatic step(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic set_idle();
    stall_i = 1'b0; flush_i = 1'b0; in_valid = 1'b0; alu_control = 3'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; alu_src = 1'b0;
    fwd_a = 2'd0; fwd_b = 2'd0; fwd_mem_data = 32'd0; fwd_wb_data = 32'd0;
    pc = 32'd0; is_branch = 1'b0; func3 = 3'd0; rd = 5'd0;
    reg_write = 1'b0; mem_write = 1'b0; result_src = 2'd0;
  endtask

  task automatic alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    set_idle();
    in_valid = 1'b1; alu_control = c; rs1_data = a; rs2_data = b;
    rd = 5'd3; reg_write = 1'b1;
  endtask

  task automatic branch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    set_idle();
    in_valid = 1'b1; is_branch = 1'b1; func3 = f; alu_control = 3'd1;
    rs1_data = a; rs2_data = b; pc = 32'h100; imm = 32'h20;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 15);
      1:       return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_inputs();
    stall_i      = ($urandom_range(0, 9) < 2);
    flush_i      = ($urandom_range(0, 9) == 0);
    in_valid     = ($urandom_range(0, 9) < 8);
    alu_control  = 3'($urandom_range(0, 7));
    rs1_data     = rnd_val();
    rs2_data     = ($urandom_range(0, 3) == 0) ? rs1_data : rnd_val();
    imm          = rnd_val();
    alu_src      = 1'($urandom_range(0, 1));
    fwd_a        = 2'($urandom_range(0, 3));
    fwd_b        = 2'($urandom_range(0, 3));
    fwd_mem_data = rnd_val();
    fwd_wb_data  = rnd_val();
    pc           = $urandom & 32'hFFFF_FFFC;
    is_branch    = 1'($urandom_range(0, 1));
    func3        = 3'($urandom_range(0, 7));
    rd           = 5'($urandom_range(0, 31));
    reg_write    = 1'($urandom_range(0, 1));
    mem_write    = 1'($urandom_range(0, 1));
    result_src   = 2'($urandom_range(0, 3));
  endtask

  initial begin
    // Reset with arbitrary inputs driven
    rst_n = 1'b0;
    randomize_inputs();
    stall_i = 1'b0; flush_i = 1'b0; in_valid = 1'b1;
    model_clear();
    #1;
    compare_all("reset");
    @(posedge clk);
    #1;
    compare_all("reset_held");
    rst_n = 1'b1;

    alu(3'd0, 32'd5, 32'd7);
    step("add_first");
    check("add_5_7", alu_result, 32'd12);
    check("add_valid", {31'd0, out_valid}, 32'd1);

    alu(3'd1, 32'd3, 32'd5);            step("sub");  check("sub_3_5", alu_result, 32'hFFFF_FFFE);
    alu(3'd5, 32'hFFFF_FFFF, 32'd1);    step("slt");  check("slt_neg", alu_result, 32'd1);
    alu(3'd4, 32'h0000_F0F0, 32'h1234); alu_src = 1'b1; imm = 32'h0FF0;
    step("xor");  check("xor_imm", alu_result, 32'h0000_FF00);
    alu(3'd7, 32'd9, 32'd4);            step("c111"); check("code111", alu_result, 32'd0);
    alu(3'd0, 32'hFFFF_FFFF, 32'd1);    step("wrap"); check("add_wrap", alu_result, 32'd0);

    // Forwarding
    alu(3'd1, 32'd50, 32'd3);
    fwd_a = 2'b10; fwd_mem_data = 32'd100; fwd_b = 2'b01; fwd_wb_data = 32'd20;
    step("fwd");
    check("fwd_sub", alu_result, 32'd80);
    check("fwd_wdata", write_data, 32'd20);
    fwd_a = 2'b11;
    step("fwd11");
    check("fwd11_sub", alu_result, 32'd30);

    // Branches
    branch(3'b000, 32'd9, 32'd9); step("beq");
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    check("beq_target", branch_target, 32'h120);
    branch(3'b001, 32'd9, 32'd9); step("bne");
    check("bne_taken", {31'd0, branch_taken}, 32'd0);
    branch(3'b100, 32'hFFFF_FFFF, 32'd1); step("blt");
    check("blt_taken", {31'd0, branch_taken}, 32'd1);
    branch(3'b101, 32'hFFFF_FFFF, 32'd1); step("bge");
    check("bge_taken", {31'd0, branch_taken}, 32'd0);
    branch(3'b000, 32'd9, 32'd9); in_valid = 1'b0; step("br_bubble");
    check("br_invalid", {31'd0, branch_taken}, 32'd0);

    // Stall holds outputs while inputs change
    alu(3'd0, 32'd5, 32'd7); step("stall_load");
    for (int i = 0; i < 3; i++) begin
      alu(3'd1, 32'd100 + 32'(i), 32'd1);
      stall_i = 1'b1;
      step("stall");
      check("stall_hold", alu_result, 32'd12);
    end
    // Flush wins over stall
    alu(3'd0, 32'd1, 32'd1); mem_write = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    step("flush_stall");
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_rw", {31'd0, reg_write_out}, 32'd0);
    check("flush_mw", {31'd0, mem_write_out}, 32'd0);

    // Bubble with live control bits
    alu(3'd0, 32'd1, 32'd2); step("pre_bubble");
    in_valid = 1'b0; reg_write = 1'b1; mem_write = 1'b1;
    step("bubble");
    check("bubble_rw", {31'd0, reg_write_out}, 32'd0);
    check("bubble_mw", {31'd0, mem_write_out}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end

    // Asynchronous reset in the middle of a cycle
    alu(3'd0, 32'd40, 32'd2); step("pre_reset");
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    compare_all("async_reset");
    #1;
    rst_n = 1'b1;
    alu(3'd0, 32'd10, 32'd11);
    step("post_reset");
    check("post_reset_add", alu_result, 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
